string_resp_bridge: RTL

STRING_RESP_BRIDGE -- requirements
Module: string_resp_bridge

---
 rtl/string_resp_bridge.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/string_resp_bridge.sv
// string_resp_bridge: buffers solver line entries {pin1, pin2, add_remove}
// in a FIFO and hands them to the HPS one at a time over a 4-phase
// req/resp handshake (IDLE -> VALID -> WAIT -> IDLE). pio_done flags that
// the solver has finished and every buffered line has been delivered.
// Optional macro STRING_RESP_SYNC_EN: adds 2-flop synchronizers on
// pio_req and pio_resp_rdy ahead of the FSM.
module string_resp_bridge #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_pin1,
    input  logic [7:0] in_pin2,
    input  logic       in_add_remove,
    input  logic       solve_start,
    input  logic       solve_done,
    input  logic       pio_req,
    input  logic       pio_resp_rdy,
    output logic       pio_resp_val,
    output logic [7:0] pio_pinpos1,
    output logic [7:0] pio_pinpos2,
    output logic       pio_add_remove,
    output logic       pio_done
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_VALID = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [16:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    state;
    logic          done_latch;
    logic          req_s;
    logic          rdy_s;
    logic          push;
    logic          pop;
    logic          empty;
    logic [16:0]   head;

`ifdef STRING_RESP_SYNC_EN
    logic [1:0] req_sync;
    logic [1:0] rdy_sync;

    // Two-flop synchronizers for the HPS handshake inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            req_sync <= '0;
            rdy_sync <= '0;
        end else begin
            req_sync <= {req_sync[0], pio_req};
            rdy_sync <= {rdy_sync[0], pio_resp_rdy};
        end
    end

    assign req_s = req_sync[1];
    assign rdy_s = rdy_sync[1];
`else
    assign req_s = pio_req;
    assign rdy_s = pio_resp_rdy;
`endif

    assign empty    = (count == '0);
    assign in_ready = (count != CNT_FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (state == ST_VALID) && rdy_s;
    assign head     = mem[rd_ptr];

    // FIFO storage write; contents need no reset since count gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_pin1, in_pin2, in_add_remove};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Response handshake FSM; data registers load only on IDLE -> VALID
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            pio_resp_val   <= 1'b0;
            pio_pinpos1    <= '0;
            pio_pinpos2    <= '0;
            pio_add_remove <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_s && !rdy_s && !empty) begin
                        pio_pinpos1    <= head[16:9];
                        pio_pinpos2    <= head[8:1];
                        pio_add_remove <= head[0];
                        pio_resp_val   <= 1'b1;
                        state          <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (rdy_s) begin
                        pio_resp_val <= 1'b0;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!rdy_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    pio_resp_val <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

    // Done latch (start wins over done) and registered all-delivered flag
    always_ff @(posedge clk) begin
        if (reset) begin
            done_latch <= 1'b0;
            pio_done   <= 1'b0;
        end else begin
            if (solve_start) begin
                done_latch <= 1'b0;
            end else if (solve_done) begin
                done_latch <= 1'b1;
            end
            // solve_start also drops pio_done on the very next edge
            pio_done <= !solve_start && done_latch && empty && (state == ST_IDLE);
        end
    end

endmodule
